// File: rtl/reset_seq.sv
// reset_seq: lock-qualified, hold-timed, staged release of CHANNELS reset outputs
module reset_seq #(
   parameter int CHANNELS    = 3,
   parameter int HOLD_CYCLES = 256,
   parameter int STAGE_GAP   = 16,
   parameter int FILT_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lock,
   input  logic                req,
   output logic [CHANNELS-1:0] rst_o,
   output logic                ready
);
   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;
   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int GW = $clog2(STAGE_GAP + 1);
   localparam int SW = $clog2(CHANNELS + 1);

   logic [1:0]          r_state    = S_WAIT;
   logic [FW-1:0]       r_filt_cnt = '0;
   logic [FW-1:0]       r_loss_cnt = '0;
   logic [HW-1:0]       r_hold_cnt = '0;
   logic [GW-1:0]       r_gap_cnt  = '0;
   logic [SW-1:0]       r_stage    = '0;
   logic [CHANNELS-1:0] r_rst_o    = '1;
   logic                r_ready    = 1'b0;

   logic w_loss, w_restart, w_filt_done, w_hold_done, w_gap_done, w_last;

   assign w_loss      = (r_state != S_WAIT) && !lock && (r_loss_cnt == FW'(FILT_CYCLES - 1));
   assign w_restart   = req || w_loss;
   assign w_filt_done = lock && (r_filt_cnt == FW'(FILT_CYCLES - 1));
   assign w_hold_done = r_hold_cnt == HW'(HOLD_CYCLES - 1);
   assign w_gap_done  = r_gap_cnt == GW'(STAGE_GAP - 1);
   assign w_last      = r_stage == SW'(CHANNELS - 1);
   assign rst_o       = r_rst_o;
   assign ready       = r_ready;

   // count consecutive low-lock edges once lock has been qualified
   always_ff @(posedge clk) begin
      if (rst || w_restart || r_state == S_WAIT || lock)
         r_loss_cnt <= '0;
      else
         r_loss_cnt <= r_loss_cnt + 1'b1;
   end

   // sequence: qualify lock, hold, then release channels low index first
   always_ff @(posedge clk) begin
      if (rst || w_restart) begin
         r_state    <= S_WAIT;
         r_filt_cnt <= '0;
         r_hold_cnt <= '0;
         r_gap_cnt  <= '0;
         r_stage    <= '0;
         r_rst_o    <= '1;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (!lock)
                  r_filt_cnt <= '0;
               else if (w_filt_done) begin
                  r_state    <= S_HOLD;
                  r_filt_cnt <= '0;
                  r_hold_cnt <= '0;
               end else
                  r_filt_cnt <= r_filt_cnt + 1'b1;
            end
            S_HOLD: begin
               if (w_hold_done) begin
                  r_hold_cnt <= '0;
                  r_rst_o    <= r_rst_o << 1;
                  r_stage    <= SW'(1);
                  r_gap_cnt  <= '0;
                  r_state    <= (CHANNELS == 1) ? S_RUN : S_REL;
                  r_ready    <= (CHANNELS == 1);
               end else
                  r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            S_REL: begin
               if (w_gap_done) begin
                  r_gap_cnt <= '0;
                  r_rst_o   <= r_rst_o << 1;
                  r_stage   <= r_stage + 1'b1;
                  if (w_last) begin
                     r_state <= S_RUN;
                     r_ready <= 1'b1;
                  end
               end else
                  r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            S_RUN: r_state <= S_RUN;
            default: r_state <= S_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: table vectors, parameter sweeps and randomized lock/req against a timing model
module tb_reset_seq;
   localparam int HOLD = 256;
   localparam int GAP  = 16;
   localparam int FILT = 4;

   logic clk = 1'b0;
   logic rst_a = 1'b0, req_a = 1'b0, lock_a = 1'b0;
   logic [2:0] rst_o_a;
   logic ready_a;
   logic rst_b = 1'b0, lock_b = 1'b0, req_b = 1'b0;
   logic [0:0] rso_b;
   logic rdy_b;
   logic [4:0] rso_c;
   logic rdy_c;

   int total = 0;
   int bad = 0;

   reset_seq dut0 (.clk(clk), .rst(rst_a), .lock(lock_a), .req(req_a), .rst_o(rst_o_a), .ready(ready_a));
   reset_seq #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .FILT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst_b), .lock(lock_b), .req(req_b), .rst_o(rso_b), .ready(rdy_b));
   reset_seq #(.CHANNELS(5), .HOLD_CYCLES(256), .STAGE_GAP(2), .FILT_CYCLES(4)) dut2 (
      .clk(clk), .rst(rst_b), .lock(lock_b), .req(req_b), .rst_o(rso_c), .ready(rdy_c));

   always #5 clk = ~clk;

   // model: qualified flag plus edges elapsed since the qualifying edge
   bit m_q = 0;
   int m_run = 0, m_loss = 0, m_n = 0;

   function automatic logic [2:0] m_rst();
      logic [2:0] e;
      for (int k = 0; k < 3; k++) e[k] = !(m_q && m_n >= HOLD + k * GAP);
      return e;
   endfunction

   task automatic model_upd();
      if (rst_a || req_a) begin
         m_q = 0; m_run = 0; m_loss = 0; m_n = 0;
      end else if (!m_q) begin
         m_run = lock_a ? m_run + 1 : 0;
         if (m_run == FILT) begin
            m_q = 1; m_run = 0; m_loss = 0; m_n = 0;
         end
      end else begin
         m_loss = lock_a ? 0 : m_loss + 1;
         if (m_loss == FILT) begin
            m_q = 0; m_loss = 0; m_n = 0;
         end else if (m_n < 1000000) m_n++;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_upd();
      #1;
      chk("model", {4'b0, ready_a, rst_o_a}, {4'b0, (m_rst() == 3'b000), m_rst()});
   endtask

   typedef struct {
      bit rst; bit req; bit lock; int n; logic [2:0] e_rst; bit e_rdy;
   } vec_t;
   vec_t tbl[$];

   initial begin
      int gl, rq, cnt;
      logic [4:0] full, exp5;
      full = '1;
      #1;
      chk("powerup", {4'b0, ready_a, rst_o_a}, 8'h07);
      // power-up release timing
      tbl.push_back('{1, 0, 1, 3, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 259, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b110, 0});
      tbl.push_back('{0, 0, 1, 15, 3'b110, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b100, 0});
      tbl.push_back('{0, 0, 1, 15, 3'b100, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b000, 1});
      // glitch rejection then qualified loss in RUN
      tbl.push_back('{0, 0, 0, 3, 3'b000, 1});
      tbl.push_back('{0, 0, 1, 1, 3'b000, 1});
      tbl.push_back('{0, 0, 0, 4, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 259, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b110, 0});
      tbl.push_back('{0, 0, 1, 16, 3'b100, 0});
      tbl.push_back('{0, 0, 1, 16, 3'b000, 1});
      // soft reset mid-release
      tbl.push_back('{0, 1, 1, 1, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 260, 3'b110, 0});
      tbl.push_back('{0, 1, 1, 1, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 259, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b110, 0});
      tbl.push_back('{0, 0, 1, 32, 3'b000, 1});
      // held request
      tbl.push_back('{0, 1, 1, 50, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 259, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b110, 0});
      tbl.push_back('{0, 0, 1, 32, 3'b000, 1});
      // lock qualification restart
      tbl.push_back('{1, 0, 1, 1, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 3, 3'b111, 0});
      tbl.push_back('{0, 0, 0, 1, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 259, 3'b111, 0});
      tbl.push_back('{0, 0, 1, 1, 3'b110, 0});
      foreach (tbl[i]) begin
         rst_a = tbl[i].rst; req_a = tbl[i].req; lock_a = tbl[i].lock;
         repeat (tbl[i].n) step();
         chk($sformatf("tbl%0d", i), {4'b0, ready_a, rst_o_a}, {4'b0, tbl[i].e_rdy, tbl[i].e_rst});
      end
      // parameter sweeps with lock steady
      rst_b = 1'b1; lock_b = 1'b1;
      repeat (2) step();
      chk("sweep_rst", {2'b0, rdy_c, rso_c}, 8'h1f);
      rst_b = 1'b0;
      for (int e = 1; e <= 268; e++) begin
         step();
         if (e == 1) chk("ch1_e1", {6'b0, rdy_b, rso_b}, 8'h01);
         if (e == 2) chk("ch1_e2", {6'b0, rdy_b, rso_b}, 8'h02);
         if (e >= 258) begin
            cnt = 0;
            for (int k = 0; k < 5; k++) if (260 + 2 * k <= e) cnt++;
            exp5 = full << cnt;
            chk($sformatf("ch5_e%0d", e), {2'b0, rdy_c, rso_c}, {2'b0, cnt == 5, exp5});
         end
      end
      // randomized lock glitches, requests and resets
      gl = 0; rq = 0;
      for (int c = 0; c < 20000; c++) begin
         if (gl > 0) begin
            lock_a = 1'b0; gl--;
         end else begin
            lock_a = 1'b1;
            if ($urandom_range(0, 399) == 0) gl = $urandom_range(1, 6);
         end
         if (rq > 0) begin
            req_a = 1'b1; rq--;
         end else begin
            req_a = 1'b0;
            if ($urandom_range(0, 1999) == 0) rq = $urandom_range(1, 5);
         end
         rst_a = ($urandom_range(0, 4999) == 0);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
